// File: rtl/sr_cpu_debug_ctrl.sv
`timescale 1ns/1ps
// Run-control and debug sequencer for sr_cpu: gates the CPU clock-enable (run/halt/step),
// stops on breakpoint/watch/budget, and time-shares the debug register-read port.
module sr_cpu_debug_ctrl #(
    parameter int unsigned WATCH_REG = 10,
    parameter int unsigned CNT_W     = 32,
    parameter int unsigned ADDR_W    = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_cmd_valid,
    output logic              o_cmd_ready,
    input  logic [2:0]        i_cmd_op,
    input  logic [31:0]       i_cmd_arg,
    output logic              o_cmd_err,
    input  logic [ADDR_W-1:0] i_im_addr,
    output logic              o_cpu_en,
    output logic [4:0]        o_reg_addr,
    input  logic [31:0]       i_reg_data,
    output logic              o_dump_valid,
    input  logic              i_dump_ready,
    output logic [4:0]        o_dump_idx,
    output logic [31:0]       o_dump_data,
    output logic              o_halted,
    output logic [2:0]        o_halt_cause,
    output logic [CNT_W-1:0]  o_run_cnt,
    output logic [CNT_W-1:0]  o_insn_cnt
);

    typedef enum logic [1:0] {
        ST_HALTED,
        ST_RUN,
        ST_STEP,
        ST_SCAN
    } state_t;

    typedef enum logic [2:0] {
        OP_NOP       = 3'd0,
        OP_RUN       = 3'd1,
        OP_HALT      = 3'd2,
        OP_STEP      = 3'd3,
        OP_SCAN      = 3'd4,
        OP_SET_BP    = 3'd5,
        OP_CLR_ALL   = 3'd6,
        OP_SET_WATCH = 3'd7
    } op_t;

    typedef enum logic [2:0] {
        CAUSE_RESET  = 3'd0,
        CAUSE_HOST   = 3'd1,
        CAUSE_STEP   = 3'd2,
        CAUSE_BP     = 3'd3,
        CAUSE_WATCH  = 3'd4,
        CAUSE_BUDGET = 3'd5
    } cause_t;

    localparam logic [4:0]       LP_WATCH_ADDR = 5'(WATCH_REG);
    localparam logic [4:0]       LP_LAST_IDX   = 5'd31;
    localparam logic [CNT_W-1:0] LP_CNT_ONE    = CNT_W'(1);

    state_t              r_state;
    cause_t              r_halt_cause;
    logic                r_cmd_err;
    logic [CNT_W-1:0]    r_budget;
    logic [CNT_W-1:0]    r_run_cnt;
    logic [CNT_W-1:0]    r_insn_cnt;
    logic [ADDR_W-1:0]   r_bp_addr;
    logic                r_bp_en;
    logic                r_bp_skip;
    logic [31:0]         r_watch_val;
    logic                r_watch_en;
    logic [4:0]          r_idx;

    state_t              w_state_nxt;
    cause_t              w_cause_nxt;
    logic                w_cmd_err_nxt;
    logic [CNT_W-1:0]    w_budget_nxt;
    logic [CNT_W-1:0]    w_run_cnt_nxt;
    logic [CNT_W-1:0]    w_insn_cnt_nxt;
    logic [ADDR_W-1:0]   w_bp_addr_nxt;
    logic                w_bp_en_nxt;
    logic                w_bp_skip_nxt;
    logic [31:0]         w_watch_val_nxt;
    logic                w_watch_en_nxt;
    logic [4:0]          w_idx_nxt;

    op_t                 w_op;
    logic                w_cmd_ready;
    logic                w_accept;
    logic                w_bp_hit;
    logic                w_watch_hit;
    logic                w_budget_hit;
    logic                w_any_hit;
    logic                w_cpu_en;

    assign w_op        = op_t'(i_cmd_op);
    assign w_cmd_ready = (r_state == ST_HALTED) || (r_state == ST_RUN);
    assign w_accept    = i_cmd_valid & w_cmd_ready;

    assign w_bp_hit     = r_bp_en & ~r_bp_skip & (i_im_addr == r_bp_addr);
    assign w_watch_hit  = r_watch_en & (i_reg_data == r_watch_val);
    assign w_budget_hit = (r_budget != '0) && (r_run_cnt == r_budget);
    assign w_any_hit    = w_bp_hit | w_watch_hit | w_budget_hit;

    // NOTE: cpu_en is combinational from the hit terms so the CPU never retires the
    // instruction that triggers the stop; the registered state only takes effect a cycle later.
    assign w_cpu_en = ((r_state == ST_RUN) & ~w_any_hit) | (r_state == ST_STEP);

    // NOTE: every variable driven here gets a default first, so no path can infer a latch.
    always_comb begin
        w_state_nxt     = r_state;
        w_cause_nxt     = r_halt_cause;
        w_cmd_err_nxt   = 1'b0;
        w_budget_nxt    = r_budget;
        w_run_cnt_nxt   = r_run_cnt;
        w_insn_cnt_nxt  = r_insn_cnt;
        w_bp_addr_nxt   = r_bp_addr;
        w_bp_en_nxt     = r_bp_en;
        w_bp_skip_nxt   = r_bp_skip;
        w_watch_val_nxt = r_watch_val;
        w_watch_en_nxt  = r_watch_en;
        w_idx_nxt       = r_idx;

        if (w_cpu_en) begin
            w_insn_cnt_nxt = r_insn_cnt + LP_CNT_ONE;
        end
        if ((r_state == ST_RUN) && w_cpu_en) begin
            w_run_cnt_nxt = r_run_cnt + LP_CNT_ONE;
        end

        // Breakpoint/watch configuration is accepted both halted and running.
        if (w_accept) begin
            case (w_op)
                OP_SET_BP: begin
                    w_bp_addr_nxt = ADDR_W'(i_cmd_arg);
                    w_bp_en_nxt   = 1'b1;
                end
                OP_SET_WATCH: begin
                    w_watch_val_nxt = i_cmd_arg;
                    w_watch_en_nxt  = 1'b1;
                end
                OP_CLR_ALL: begin
                    w_bp_en_nxt    = 1'b0;
                    w_watch_en_nxt = 1'b0;
                end
                default: ;
            endcase
        end

        case (r_state)
            ST_HALTED: begin
                if (w_accept) begin
                    case (w_op)
                        OP_RUN: begin
                            w_state_nxt   = ST_RUN;
                            w_budget_nxt  = CNT_W'(i_cmd_arg);
                            w_run_cnt_nxt = '0;
                            w_bp_skip_nxt = 1'b1;
                        end
                        OP_STEP: w_state_nxt = ST_STEP;
                        OP_SCAN: begin
                            w_state_nxt = ST_SCAN;
                            w_idx_nxt   = '0;
                        end
                        default: ;
                    endcase
                end
            end
            ST_RUN: begin
                w_bp_skip_nxt = 1'b0;
                if (w_accept) begin
                    case (w_op)
                        OP_HALT: begin
                            w_state_nxt = ST_HALTED;
                            w_cause_nxt = CAUSE_HOST;
                        end
                        OP_RUN, OP_STEP, OP_SCAN: w_cmd_err_nxt = 1'b1;
                        default: ;
                    endcase
                end
                // A hit overrides a simultaneous host HALT as the recorded cause.
                if (w_any_hit) begin
                    w_state_nxt = ST_HALTED;
                    if (w_bp_hit) begin
                        w_cause_nxt = CAUSE_BP;
                    end else if (w_watch_hit) begin
                        w_cause_nxt = CAUSE_WATCH;
                    end else begin
                        w_cause_nxt = CAUSE_BUDGET;
                    end
                end
            end
            ST_STEP: begin
                w_state_nxt = ST_HALTED;
                w_cause_nxt = CAUSE_STEP;
            end
            ST_SCAN: begin
                if (i_dump_ready) begin
                    w_idx_nxt = r_idx + 5'd1;
                    if (r_idx == LP_LAST_IDX) begin
                        w_state_nxt = ST_HALTED;
                    end
                end
            end
            default: w_state_nxt = ST_HALTED;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= ST_HALTED;
            r_halt_cause <= CAUSE_RESET;
            r_cmd_err    <= 1'b0;
            r_budget     <= '0;
            r_run_cnt    <= '0;
            r_insn_cnt   <= '0;
            r_bp_addr    <= '0;
            r_bp_en      <= 1'b0;
            r_bp_skip    <= 1'b0;
            r_watch_val  <= '0;
            r_watch_en   <= 1'b0;
            r_idx        <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_halt_cause <= w_cause_nxt;
            r_cmd_err    <= w_cmd_err_nxt;
            r_budget     <= w_budget_nxt;
            r_run_cnt    <= w_run_cnt_nxt;
            r_insn_cnt   <= w_insn_cnt_nxt;
            r_bp_addr    <= w_bp_addr_nxt;
            r_bp_en      <= w_bp_en_nxt;
            r_bp_skip    <= w_bp_skip_nxt;
            r_watch_val  <= w_watch_val_nxt;
            r_watch_en   <= w_watch_en_nxt;
            r_idx        <= w_idx_nxt;
        end
    end

    // The register file is frozen while scanning, so passing read data straight through is stable.
    assign o_cpu_en     = w_cpu_en;
    assign o_cmd_ready  = w_cmd_ready;
    assign o_cmd_err    = r_cmd_err;
    assign o_halted     = (r_state == ST_HALTED);
    assign o_halt_cause = r_halt_cause;
    assign o_dump_valid = (r_state == ST_SCAN);
    assign o_dump_idx   = r_idx;
    assign o_dump_data  = i_reg_data;
    assign o_reg_addr   = (r_state == ST_SCAN) ? r_idx : LP_WATCH_ADDR;
    assign o_run_cnt    = r_run_cnt;
    assign o_insn_cnt   = r_insn_cnt;

endmodule

// File: tb/tb_sr_cpu_debug_ctrl.sv
`timescale 1ns/1ps
// Directed bench for sr_cpu_debug_ctrl driving a tiny Fibonacci CPU model through cpu_en.
module tb_sr_cpu_debug_ctrl;

    localparam logic [2:0] OP_RUN = 3'd1, OP_HALT = 3'd2, OP_STEP = 3'd3, OP_SCAN = 3'd4;
    localparam logic [2:0] OP_SET_BP = 3'd5, OP_CLR_ALL = 3'd6, OP_SET_WATCH = 3'd7;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [2:0]  cmd_op = 3'd0;
    logic [31:0] cmd_arg = 32'd0;
    logic        cmd_err;
    logic [31:0] im_addr;
    logic        cpu_en;
    logic [4:0]  reg_addr;
    logic [31:0] reg_data;
    logic        dump_valid;
    logic        dump_ready = 1'b0;
    logic [4:0]  dump_idx;
    logic [31:0] dump_data;
    logic        halted;
    logic [2:0]  halt_cause;
    logic [31:0] run_cnt;
    logic [31:0] insn_cnt;

    always #5 clk = ~clk;

    sr_cpu_debug_ctrl #(.WATCH_REG(10), .CNT_W(32), .ADDR_W(32)) dut (
        .clk(clk), .rst(rst),
        .i_cmd_valid(cmd_valid), .o_cmd_ready(cmd_ready), .i_cmd_op(cmd_op),
        .i_cmd_arg(cmd_arg), .o_cmd_err(cmd_err),
        .i_im_addr(im_addr), .o_cpu_en(cpu_en),
        .o_reg_addr(reg_addr), .i_reg_data(reg_data),
        .o_dump_valid(dump_valid), .i_dump_ready(dump_ready),
        .o_dump_idx(dump_idx), .o_dump_data(dump_data),
        .o_halted(halted), .o_halt_cause(halt_cause),
        .o_run_cnt(run_cnt), .o_insn_cnt(insn_cnt)
    );

    // CPU model: x10 (a0) walks the Fibonacci sequence; loop body at 0x8..0x14.
    logic [31:0] pc;
    logic [31:0] regs [32];
    assign im_addr  = pc;
    assign reg_data = regs[reg_addr];

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc <= 32'h0;
            for (int i = 0; i < 32; i++) regs[i] <= (i == 0) ? 32'h0 : 32'h0101_0000 + 32'(i);
        end else if (cpu_en) begin
            case (pc)
                32'h00: begin regs[10] <= 32'd0;                pc <= 32'h04; end
                32'h04: begin regs[11] <= 32'd1;                pc <= 32'h08; end
                32'h08: begin regs[5]  <= regs[10] + regs[11];  pc <= 32'h0C; end
                32'h0C: begin regs[10] <= regs[11];             pc <= 32'h10; end
                32'h10: begin regs[11] <= regs[5];              pc <= 32'h14; end
                32'h14: begin                                   pc <= 32'h08; end
                default: pc <= 32'h0;
            endcase
        end
    end

    int en_cycles = 0;
    always @(posedge clk) if (rst && cpu_en) en_cycles <= en_cycles + 1;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic cmd(input logic [2:0] op, input logic [31:0] arg);
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_arg   = arg;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        cmd_op    = 3'd0;
        cmd_arg   = 32'd0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
    endtask

    logic        saw_stop;
    logic [31:0] stop_pc;

    task automatic wait_halt(input string tag, input int max_cyc);
        saw_stop = 1'b0;
        stop_pc  = 32'hFFFF_FFFF;
        for (int c = 0; c < max_cyc; c++) begin
            @(negedge clk);
            if (halted) break;
            if (!cpu_en) begin
                saw_stop = 1'b1;
                stop_pc  = pc;
            end
        end
        check({tag, "_halted"}, halted, 1);
    endtask

    int          e0;
    int          exp_idx;
    int          xfers;
    logic        prev_ready;
    logic [31:0] held;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(negedge clk);
        check("rst_halted", halted, 1);
        check("rst_cause", halt_cause, 0);
        check("rst_cpu_en", cpu_en, 0);
        check("rst_ready", cmd_ready, 1);
        check("rst_err", cmd_err, 0);
        check("rst_dump_valid", dump_valid, 0);
        check("rst_dump_idx", dump_idx, 0);
        check("rst_reg_addr", reg_addr, 10);
        check("rst_run_cnt", run_cnt, 0);
        check("rst_insn_cnt", insn_cnt, 0);
        rst = 1'b1;

        // Three single steps from reset.
        e0 = en_cycles;
        for (int k = 1; k <= 3; k++) begin
            cmd(OP_STEP, 32'd0);
            @(negedge clk);
            check("step_en", cpu_en, 1);
            check("step_ready", cmd_ready, 0);
            @(negedge clk);
            check("step_pc", pc, 64'(4 * k));
            check("step_halted", halted, 1);
            check("step_en_off", cpu_en, 0);
        end
        check("step_en_cycles", en_cycles - e0, 3);
        check("step_insn_cnt", insn_cnt, 3);
        check("step_run_cnt", run_cnt, 0);
        check("step_cause", halt_cause, 2);

        // Budgeted run of 5, then host halt with an illegal STEP in between.
        e0 = en_cycles;
        cmd(OP_RUN, 32'd5);
        wait_halt("budget", 50);
        check("budget_cause", halt_cause, 5);
        check("budget_run_cnt", run_cnt, 5);
        check("budget_en_cycles", en_cycles - e0, 5);
        check("budget_stop_seen", saw_stop, 1);
        check("budget_insn_cnt", insn_cnt, 8);
        check("budget_pc", pc, 32'h10);

        cmd(OP_RUN, 32'd0);
        cmd(OP_STEP, 32'd0);
        #1;
        check("run_step_err", cmd_err, 1);
        check("run_step_state", halted, 0);
        cmd(OP_HALT, 32'd0);
        @(negedge clk);
        check("host_halted", halted, 1);
        check("host_cause", halt_cause, 1);
        check("host_run_cnt", run_cnt, 2);
        check("host_err_clear", cmd_err, 0);
        check("host_insn_cnt", insn_cnt, 10);
        check("host_pc", pc, 32'h08);

        // Watch stop at fib(32) in a0.
        do_reset();
        check("wrst_insn_cnt", insn_cnt, 0);
        cmd(OP_SET_WATCH, 32'h0021_3d05);
        cmd(OP_RUN, 32'd0);
        wait_halt("watch", 1000);
        check("watch_cause", halt_cause, 4);
        check("watch_stop_seen", saw_stop, 1);
        check("watch_stop_pc", stop_pc, 32'h10);
        check("watch_a0", regs[10], 32'h0021_3d05);
        check("watch_pc", pc, 32'h10);
        check("watch_insn_cnt", insn_cnt, 128);
        check("watch_run_cnt", run_cnt, 128);

        // Breakpoint at 0x10, then resume across it once.
        do_reset();
        cmd(OP_SET_BP, 32'h10);
        cmd(OP_RUN, 32'd0);
        wait_halt("bp1", 100);
        check("bp1_cause", halt_cause, 3);
        check("bp1_stop_seen", saw_stop, 1);
        check("bp1_stop_pc", stop_pc, 32'h10);
        check("bp1_run_cnt", run_cnt, 4);
        check("bp1_pc", pc, 32'h10);
        cmd(OP_RUN, 32'd0);
        wait_halt("bp2", 100);
        check("bp2_cause", halt_cause, 3);
        check("bp2_run_cnt", run_cnt, 4);
        check("bp2_pc", pc, 32'h10);
        check("bp2_insn_cnt", insn_cnt, 8);

        // Register dump with alternating ready and a refused STEP.
        cmd(OP_SCAN, 32'd0);
        exp_idx    = 0;
        xfers      = 0;
        prev_ready = 1'b1;
        held       = 32'd0;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            if (!dump_valid) break;
            check("scan_idx", dump_idx, 64'(exp_idx));
            check("scan_data", dump_data, regs[exp_idx]);
            if (c == 0) check("scan_x0", dump_data, 0);
            if (!prev_ready) check("scan_hold", dump_data, held);
            if (c < 4) begin
                check("scan_cmd_ready", cmd_ready, 0);
                cmd_valid = 1'b1;
                cmd_op    = OP_STEP;
            end else begin
                cmd_valid = 1'b0;
                cmd_op    = 3'd0;
            end
            dump_ready = (c % 2 == 0);
            held       = dump_data;
            prev_ready = dump_ready;
            if (dump_ready) begin
                exp_idx++;
                xfers++;
            end
        end
        cmd_valid  = 1'b0;
        dump_ready = 1'b0;
        check("scan_xfers", xfers, 32);
        check("scan_halted", halted, 1);
        check("scan_valid_off", dump_valid, 0);
        check("scan_cause", halt_cause, 3);
        check("scan_reg_addr", reg_addr, 10);
        check("scan_insn_cnt", insn_cnt, 8);

        // Asynchronous reset in the middle of a run.
        cmd(OP_CLR_ALL, 32'd0);
        cmd(OP_RUN, 32'd0);
        repeat (3) @(negedge clk);
        check("prerst_en", cpu_en, 1);
        #2 rst = 1'b0;
        #1;
        check("rrst_cpu_en", cpu_en, 0);
        check("rrst_halted", halted, 1);
        check("rrst_cause", halt_cause, 0);
        check("rrst_run_cnt", run_cnt, 0);
        check("rrst_insn_cnt", insn_cnt, 0);
        @(negedge clk);
        rst = 1'b1;

        // Asynchronous reset in the middle of a scan, with stale bp/watch armed.
        cmd(OP_SET_BP, 32'h08);
        cmd(OP_SET_WATCH, 32'd0);
        cmd(OP_SCAN, 32'd0);
        dump_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 dump_ready = 1'b0;
        @(negedge clk);
        check("prerst_dump_idx", dump_idx, 3);
        check("prerst_dump_valid", dump_valid, 1);
        #2 rst = 1'b0;
        #1;
        check("srst_dump_valid", dump_valid, 0);
        check("srst_cpu_en", cpu_en, 0);
        check("srst_cause", halt_cause, 0);
        check("srst_dump_idx", dump_idx, 0);
        check("srst_reg_addr", reg_addr, 10);
        @(negedge clk);
        rst = 1'b1;

        cmd(OP_RUN, 32'd6);
        wait_halt("postrst", 50);
        check("postrst_cause", halt_cause, 5);
        check("postrst_run_cnt", run_cnt, 6);
        check("postrst_pc", pc, 32'h08);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/sr_cpu_debug_ctrl.md
Name: sr_cpu_debug_ctrl

Overview:
Run-control and debug sequencer for the single-cycle sr_cpu. It gates CPU execution through a clock-enable (run / halt / single-step). It stops the CPU precisely on a PC breakpoint, a watched-register value, or an instruction budget. It also owns the shared debug register-read port (reg_addr/reg_data), time-sharing it between run-time watch monitoring and a halted register-dump stream to the host.

Parameters:
WATCH_REG, 10, register index monitored while running (a0)
CNT_W, 32, width of instruction counters and budget
ADDR_W, 32, PC / breakpoint width

Ports:
clk  in  1  clock
rst  in  1  asynchronous reset, active-low
cmd_valid  in  1  host command valid
cmd_ready  out  1  command accepted when valid&ready at posedge
cmd_op  in  3  0 NOP, 1 RUN, 2 HALT, 3 STEP, 4 SCAN, 5 SET_BP, 6 CLR_ALL, 7 SET_WATCH
cmd_arg  in  32  RUN: budget (0 = unlimited); SET_BP: address; SET_WATCH: value
cmd_err  out  1  one-cycle pulse: accepted command illegal in current state
im_addr  in  ADDR_W  CPU current PC
cpu_en  out  1  CPU clock-enable; the CPU retires one instruction per clk with cpu_en=1
reg_addr  out  5  debug register-read address to CPU
reg_data  in  32  debug register-read data (combinational from register file)
dump_valid  out  1  scan stream valid
dump_ready  in  1  scan stream ready
dump_idx  out  5  register index of dump_data
dump_data  out  32  register value
halted  out  1  state == HALTED
halt_cause  out  3  0 RESET, 1 HOST, 2 STEP, 3 BP, 4 WATCH, 5 BUDGET
run_cnt  out  CNT_W  instructions retired since last accepted RUN
insn_cnt  out  CNT_W  instructions retired since reset (wraps)

Behaviour:
- Reset (rst=0, async): state HALTED; cpu_en=0; cmd_ready=1; cmd_err=0; reg_addr=WATCH_REG; dump_valid=0; dump_idx=0; halt_cause=RESET; run_cnt=insn_cnt=0; bp_en=watch_en=0; budget=0. Reset mid-RUN/SCAN aborts immediately; cpu_en drops asynchronously (decoded from state).
- States: HALTED, RUN, STEP, SCAN.
- cmd_ready=1 in HALTED and RUN, 0 in STEP and SCAN.
- HALTED:
  - RUN → RUN; budget←arg; run_cnt←0; bp_skip←1.
  - STEP → STEP.
  - SCAN → SCAN; idx←0.
  - HALT, NOP → no-op.
  - SET_BP: bp_addr←arg, bp_en←1.
  - SET_WATCH: watch_val←arg, watch_en←1.
  - CLR_ALL: bp_en←0, watch_en←0.
- RUN:
  - reg_addr=WATCH_REG.
  - bp_hit = bp_en & ~bp_skip & (im_addr==bp_addr).
  - watch_hit = watch_en & (reg_data==watch_val).
  - budget_hit = (budget!=0) & (run_cnt==budget).
  - cpu_en = ~(bp_hit|watch_hit|budget_hit), combinational, so the halting instruction is not executed.
  - Any hit → HALTED at next edge. Cause priority: BP > WATCH > BUDGET.
  - bp_skip clears after the first RUN cycle, so resuming at a breakpointed PC executes it once.
  - HALT accepted → HALTED, cause HOST. cpu_en stays 1 in the accept cycle unless a hit occurs in that same cycle; a hit's cause overrides HOST.
  - SET_BP/SET_WATCH/CLR_ALL are applied, effective next cycle.
  - RUN/STEP/SCAN are dropped with a cmd_err pulse.
- STEP: exactly one cycle with cpu_en=1, no hit checks → HALTED, cause STEP.
- Counters: run_cnt and insn_cnt increment on every edge where cpu_en=1. A STEP increments insn_cnt only.
- SCAN:
  - cpu_en=0; reg_addr=dump_idx=idx; dump_valid=1; dump_data=reg_data (stable, since the CPU is frozen).
  - On valid&ready, idx increments.
  - Acceptance at idx=31 → HALTED, dump_valid=0, reg_addr←WATCH_REG; halt_cause unchanged.
  - Holding dump_ready=0 stalls indefinitely with data held stable.
- cmd_err is cleared every cycle except the pulse cycle. All outputs except cpu_en are registered or decoded directly from state registers.

Test Plan:
1. Reset, then RUN arg=0 with SET_WATCH 0x00213d05 issued beforehand on the Fibonacci ROM → halted=1 and halt_cause=4 within 1000 cycles; reg_data at WATCH_REG=0x00213d05; cpu_en=0 in the hit cycle.
2. SET_BP 0x10, RUN → cpu_en=0 while im_addr=0x10, halt_cause=3. A second RUN executes 0x10 once (bp_skip) and halts on the next arrival at 0x10.
3. STEP ×3 from reset → insn_cnt=3, each STEP has cpu_en high for exactly 1 cycle, im_addr advances 0→4→8→0xC, halt_cause=2.
4. RUN arg=5 → run_cnt=5, halt_cause=5, exactly 5 cpu_en cycles. RUN then HALT after 2 cycles → halt_cause=1.
5. SCAN with dump_ready toggled 1/0 → 32 transfers, dump_idx 0..31 in order, dump_data[0]=0, data stable while ready=0, returns to HALTED. STEP issued during SCAN is not accepted (cmd_ready=0).
6. Assert rst mid-RUN and mid-SCAN → cpu_en=0 and dump_valid=0 immediately, halt_cause=0, counters 0, bp/watch disabled. STEP sent during RUN → cmd_err pulse, state stays RUN.
